// File: rtl/fpa_issue_queue_if.sv
// Operand/result handshake bundle for the FP add/mul issue queue.
// master = producer/consumer side, slave = queue side.
interface fpa_issue_queue_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_A;
   logic [WIDTH-1:0] in_B;
   logic             in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_op;

   modport master (
      output in_valid, in_A, in_B, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_op
   );

   modport slave (
      input  in_valid, in_A, in_B, in_op, out_ready,
      output in_ready, out_valid, out_result, out_op
   );
endinterface

// File: rtl/fpa_issue_queue.sv
// Operand FIFO, issue register and result register wrapped around
// a combinational FP add/multiply unit.
module fpa_issue_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   fpa_issue_queue_if.slave        bus,
   output logic [WIDTH-1:0]        fpa_A,
   output logic [WIDTH-1:0]        fpa_B,
   output logic                    fpa_op,
   input  logic [WIDTH-1:0]        fpa_result,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] a_mem [DEPTH];
   logic [WIDTH-1:0] b_mem [DEPTH];
   logic             op_mem [DEPTH];

   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             s1v_q, s1v_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             op_q, op_d;
   logic             s2v_q, s2v_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             rop_q, rop_d;

   logic push;
   logic s1_load;
   logic s2_load;

   // in_ready looks only at occupancy, never at the same-cycle pop
   assign bus.in_ready = (cnt_q < CW'(DEPTH));
   assign push    = bus.in_valid & bus.in_ready;
   assign s2_load = s1v_q & (~s2v_q | bus.out_ready);
   assign s1_load = (cnt_q != '0) & (~s1v_q | s2_load);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(s1_load);
      s1v_d = s1v_q;
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      s2v_d = s2v_q;
      res_d = res_q;
      rop_d = rop_q;
      if (push) wr_d = wr_q + AW'(1);
      if (s1_load) begin
         rd_d  = rd_q + AW'(1);
         a_d   = a_mem[rd_q];
         b_d   = b_mem[rd_q];
         op_d  = op_mem[rd_q];
         s1v_d = 1'b1;
      end else if (s2_load) begin
         s1v_d = 1'b0;
      end
      if (s2_load) begin
         res_d = fpa_result;
         rop_d = op_q;
         s2v_d = 1'b1;
      end else if (s2v_q & bus.out_ready) begin
         s2v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         s1v_q <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= 1'b0;
         s2v_q <= 1'b0;
         res_q <= '0;
         rop_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         s1v_q <= s1v_d;
         a_q   <= a_d;
         b_q   <= b_d;
         op_q  <= op_d;
         s2v_q <= s2v_d;
         res_q <= res_d;
         rop_q <= rop_d;
      end
   end

   // Storage array needs no reset; occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         a_mem[wr_q]  <= bus.in_A;
         b_mem[wr_q]  <= bus.in_B;
         op_mem[wr_q] <= bus.in_op;
      end
   end

   assign fpa_A          = a_q;
   assign fpa_B          = b_q;
   assign fpa_op         = op_q;
   assign bus.out_valid  = s2v_q;
   assign bus.out_result = res_q;
   assign bus.out_op     = rop_q;
   assign count          = cnt_q;
endmodule

// File: tb/tb_fpa_issue_queue.sv
// Bench for fpa_issue_queue with a stand-in arithmetic unit and a
// queue-based scoreboard of accepted pairs.
module tb_fpa_issue_queue;
   localparam int DEPTH = 4;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fpa_issue_queue_if #(.WIDTH(WIDTH)) bus ();
   logic [WIDTH-1:0]       fpa_A, fpa_B, fpa_result;
   logic                   fpa_op;
   logic [$clog2(DEPTH):0] count;

   fpa_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fpa_A      (fpa_A),
      .fpa_B      (fpa_B),
      .fpa_op     (fpa_op),
      .fpa_result (fpa_result),
      .count      (count)
   );

   // Stand-in unit: exact IEEE results for the directed pairs, a
   // deterministic mix otherwise so every pair has a distinct result.
   function automatic logic [31:0] unit(logic [31:0] a, logic [31:0] b,
                                        logic op);
      if (!op && a == 32'h3F800000 && b == 32'h40000000)
         return 32'h40400000;
      if (op && a == 32'h40000000 && b == 32'h40400000)
         return 32'h40C00000;
      if (op) return a ^ {b[15:0], b[31:16]};
      return a + b;
   endfunction

   assign fpa_result = unit(fpa_A, fpa_B, fpa_op);

   typedef struct packed {
      logic [31:0] r;
      logic        op;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_acc = 0;
   int   n_dlv = 0;

   task automatic tick();
      logic        acc, dlv, o;
      logic [31:0] r;
      exp_t        e, x;
      acc = bus.in_valid & bus.in_ready;
      dlv = bus.out_valid & bus.out_ready;
      r   = bus.out_result;
      o   = bus.out_op;
      e.r  = unit(bus.in_A, bus.in_B, bus.in_op);
      e.op = bus.in_op;
      @(posedge clk);
      #1;
      if (rst) begin
         sb.delete();
      end else begin
         if (acc) begin
            sb.push_back(e);
            n_acc++;
         end
         if (dlv) begin
            checks++;
            n_dlv++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result got %h/%0d want none",
                        r, o);
            end else begin
               x = sb.pop_front();
               if ({r, o} !== {x.r, x.op}) begin
                  errors++;
                  $display("FAIL result_order got %h/%0d want %h/%0d",
                           r, o, x.r, x.op);
               end
            end
         end
      end
      checks++;
      if (bus.in_ready !== (count < DEPTH)) begin
         errors++;
         $display("FAIL in_ready got %0b want %0b (count %0d)",
                  bus.in_ready, count < DEPTH, count);
      end
   endtask

   task automatic rand_pair();
      bus.in_A  = $urandom;
      bus.in_B  = $urandom;
      bus.in_op = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (sb.size() == 0 && !bus.out_valid) return;
         tick();
      end
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", sb.size());
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      rand_pair();
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (count !== 0 || bus.out_valid !== 1'b0 ||
          bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctl got cnt %0d ov %0b ir %0b want 0 0 1",
                  count, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (fpa_A !== 0 || fpa_B !== 0 || fpa_op !== 0 ||
          bus.out_result !== 0 || bus.out_op !== 0) begin
         errors++;
         $display("FAIL reset_data got %h %h %0b %h %0b want zeros",
                  fpa_A, fpa_B, fpa_op, bus.out_result, bus.out_op);
      end
   endtask

   task automatic test_single(logic [31:0] a, logic [31:0] b, logic op,
                              logic [31:0] want);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_A = a;
      bus.in_B = b;
      bus.in_op = op;
      tick();
      bus.in_valid = 1'b0;
      tick();
      checks++;
      if (fpa_A !== a || fpa_B !== b || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL issue_stage got %h %h ov %0b want %h %h ov 0",
                  fpa_A, fpa_B, bus.out_valid, a, b);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== want ||
          bus.out_op !== op) begin
         errors++;
         $display("FAIL single_result got %0b %h %0b want 1 %h %0b",
                  bus.out_valid, bus.out_result, bus.out_op, want, op);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_clear got %0b want 0", bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      int a0, d0;
      a0 = n_acc;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_pair();
         tick();
      end
      checks++;
      if (n_acc - a0 !== 6) begin
         errors++;
         $display("FAIL bp_accepted got %0d want 6", n_acc - a0);
      end
      checks++;
      if (bus.in_ready !== 1'b0 || count !== DEPTH) begin
         errors++;
         $display("FAIL bp_full got ir %0b cnt %0d want 0 %0d",
                  bus.in_ready, count, DEPTH);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      d0 = n_dlv;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_return got %0b want 1", bus.in_ready);
      end
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (n_dlv - d0 !== 6 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got %0d ov %0b want 6 ov 0",
                  n_dlv - d0, bus.out_valid);
      end
   endtask

   task automatic test_streaming();
      logic want;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 22; k++) begin
         bus.in_valid = (k < 20);
         rand_pair();
         if (k < 20) begin
            checks++;
            if (bus.in_ready !== 1'b1 || count > 1) begin
               errors++;
               $display("FAIL stream_in got ir %0b cnt %0d want 1 <=1",
                        bus.in_ready, count);
            end
         end
         tick();
         want = (k >= 2);
         checks++;
         if (bus.out_valid !== want) begin
            errors++;
            $display("FAIL stream_valid edge %0d got %0b want %0b",
                     k, bus.out_valid, want);
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int d0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_pair();
         tick();
      end
      checks++;
      if (count !== 3 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_fill got cnt %0d ov %0b want 3 1",
                  count, bus.out_valid);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (count !== 0 || bus.out_valid !== 1'b0 || fpa_A !== 0 ||
          bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got cnt %0d ov %0b A %h ir %0b",
                  count, bus.out_valid, fpa_A, bus.in_ready);
      end
      d0 = n_dlv;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      rand_pair();
      tick();
      drain();
      checks++;
      if (n_dlv - d0 !== 1) begin
         errors++;
         $display("FAIL mid_after got %0d results want 1", n_dlv - d0);
      end
   endtask

   task automatic test_wrap();
      int a0, d0, cyc;
      a0 = n_acc;
      d0 = n_dlv;
      cyc = 0;
      while (cyc < 200) begin
         bus.in_valid  = (n_acc - a0 < 3 * DEPTH);
         bus.out_ready = cyc[0];
         rand_pair();
         tick();
         cyc++;
         if (n_acc - a0 == 3 * DEPTH && sb.size() == 0 &&
             !bus.out_valid) break;
      end
      checks++;
      if (n_acc - a0 !== 3 * DEPTH || n_dlv - d0 !== 3 * DEPTH ||
          sb.size() !== 0) begin
         errors++;
         $display("FAIL wrap got acc %0d dlv %0d pend %0d want %0d %0d 0",
                  n_acc - a0, n_dlv - d0, sb.size(), 3 * DEPTH,
                  3 * DEPTH);
      end
   endtask

   initial begin
      test_reset();
      test_single(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
      test_single(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000);
      test_backpressure();
      test_streaming();
      test_reset_mid();
      test_wrap();
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
